// File: rtl/opto_shot_scheduler.sv
// Laser shot scheduler: sequences TDC init, ready check, laser fire and the measurement
// window of every shot, with runtime config that is shadowed until the next shot boundary.
module opto_shot_scheduler #(
    parameter logic [15:0] DEF_PERIOD = 16'd333,
    parameter logic [15:0] DEF_LEAD   = 16'd70,
    parameter logic [15:0] DEF_WIN    = 16'd200,
    parameter logic [15:0] MIN_PERIOD = 16'd16
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_cfg_wr,
    input  logic [15:0] i_cfg_period,
    input  logic [15:0] i_cfg_lead,
    input  logic [15:0] i_cfg_win,
    input  logic        i_start,
    input  logic        i_stop,
    input  logic        i_tdc_ready,
    output logic        o_tdc_init,
    output logic        o_laser_fire,
    output logic        o_win_open,
    output logic        o_miss,
    output logic        o_cfg_err,
    output logic        o_busy,
    output logic [31:0] o_shot_cnt
);

    typedef enum logic [1:0] {ST_IDLE, ST_ARM, ST_RUN, ST_DRAIN} state_t;

    state_t      state_q, state_d;
    logic [15:0] cnt_q, cnt_d;
    logic [15:0] last_q, last_d;
    logic [15:0] init_at_q, init_at_d;
    logic [15:0] win_q, win_d;
    logic [15:0] pend_period_q, pend_period_d;
    logic [15:0] pend_lead_q, pend_lead_d;
    logic [15:0] pend_win_q, pend_win_d;
    logic [15:0] win_rem_q, win_rem_d;
    logic        rdy_q, rdy_d;
    logic        tdc_init_q, tdc_init_d;
    logic        laser_fire_q, laser_fire_d;
    logic        win_open_q, win_open_d;
    logic        miss_q, miss_d;
    logic        cfg_err_q, cfg_err_d;
    logic        busy_q, busy_d;
    logic [31:0] shot_cnt_q, shot_cnt_d;

    logic cfg_valid;
    logic cfg_load;
    logic at_wrap;
    logic at_init;

    // The period term guards the subtractions below against wrap-around.
    assign cfg_valid = (i_cfg_period >= MIN_PERIOD) &&
                       (i_cfg_lead >= 16'd4) &&
                       (i_cfg_lead <= i_cfg_period - 16'd4) &&
                       (i_cfg_win <= i_cfg_period - i_cfg_lead - 16'd1);
    assign cfg_load  = i_cfg_wr && cfg_valid;
    assign at_wrap   = (state_q == ST_RUN) && (cnt_q == last_q);
    assign at_init   = (state_q == ST_RUN) && (cnt_q == init_at_q);

    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        last_d        = last_q;
        init_at_d     = init_at_q;
        win_d         = win_q;
        pend_period_d = pend_period_q;
        pend_lead_d   = pend_lead_q;
        pend_win_d    = pend_win_q;
        win_rem_d     = win_rem_q;
        shot_cnt_d    = shot_cnt_q;
        tdc_init_d    = 1'b0;
        laser_fire_d  = 1'b0;
        miss_d        = 1'b0;
        win_open_d    = win_open_q;
        cfg_err_d     = i_cfg_wr && !cfg_valid;

        if (cfg_load) begin
            pend_period_d = i_cfg_period;
            pend_lead_d   = i_cfg_lead;
            pend_win_d    = i_cfg_win;
        end

        // Window length is taken from the config active in the fire cycle.
        if (laser_fire_q) begin
            win_open_d = (win_q != 16'd0);
            win_rem_d  = win_q - 16'd1;
        end else if (win_open_q) begin
            if (win_rem_q == 16'd0) begin
                win_open_d = 1'b0;
            end else begin
                win_rem_d = win_rem_q - 16'd1;
            end
        end

        case (state_q)
            ST_IDLE: begin
                cnt_d = 16'd0;
                if (cfg_load) begin
                    last_d    = i_cfg_period - 16'd1;
                    init_at_d = i_cfg_period - i_cfg_lead - 16'd1;
                    win_d     = i_cfg_win;
                end else begin
                    last_d    = pend_period_q - 16'd1;
                    init_at_d = pend_period_q - pend_lead_q - 16'd1;
                    win_d     = pend_win_q;
                end
                if (i_start && !i_stop) begin
                    state_d    = ST_ARM;
                    shot_cnt_d = 32'd0;
                end
            end
            ST_ARM: begin
                cnt_d   = cnt_q + 16'd1;
                state_d = i_stop ? ST_DRAIN : ST_RUN;
            end
            ST_RUN: begin
                if (i_stop) begin
                    state_d = ST_DRAIN;
                end else begin
                    cnt_d      = at_wrap ? 16'd0 : cnt_q + 16'd1;
                    tdc_init_d = at_init;
                    if (at_wrap) begin
                        // Pending config takes over for the period that starts now.
                        last_d    = pend_period_q - 16'd1;
                        init_at_d = pend_period_q - pend_lead_q - 16'd1;
                        win_d     = pend_win_q;
                        if (rdy_q || i_tdc_ready) begin
                            laser_fire_d = 1'b1;
                            if (shot_cnt_q != 32'hFFFF_FFFF) begin
                                shot_cnt_d = shot_cnt_q + 32'd1;
                            end
                        end else begin
                            miss_d = 1'b1;
                        end
                    end
                end
            end
            default: begin
                if (!win_open_d) begin
                    state_d = ST_IDLE;
                end
            end
        endcase

        // Ready seen during the init cycle itself does not count.
        if (tdc_init_d) begin
            rdy_d = 1'b0;
        end else if (i_tdc_ready && !tdc_init_q) begin
            rdy_d = 1'b1;
        end else begin
            rdy_d = rdy_q;
        end

        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q       <= ST_IDLE;
            cnt_q         <= 16'd0;
            last_q        <= DEF_PERIOD - 16'd1;
            init_at_q     <= DEF_PERIOD - DEF_LEAD - 16'd1;
            win_q         <= DEF_WIN;
            pend_period_q <= DEF_PERIOD;
            pend_lead_q   <= DEF_LEAD;
            pend_win_q    <= DEF_WIN;
            win_rem_q     <= 16'd0;
            rdy_q         <= 1'b0;
            tdc_init_q    <= 1'b0;
            laser_fire_q  <= 1'b0;
            win_open_q    <= 1'b0;
            miss_q        <= 1'b0;
            cfg_err_q     <= 1'b0;
            busy_q        <= 1'b0;
            shot_cnt_q    <= 32'd0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            last_q        <= last_d;
            init_at_q     <= init_at_d;
            win_q         <= win_d;
            pend_period_q <= pend_period_d;
            pend_lead_q   <= pend_lead_d;
            pend_win_q    <= pend_win_d;
            win_rem_q     <= win_rem_d;
            rdy_q         <= rdy_d;
            tdc_init_q    <= tdc_init_d;
            laser_fire_q  <= laser_fire_d;
            win_open_q    <= win_open_d;
            miss_q        <= miss_d;
            cfg_err_q     <= cfg_err_d;
            busy_q        <= busy_d;
            shot_cnt_q    <= shot_cnt_d;
        end
    end

    assign o_tdc_init   = tdc_init_q;
    assign o_laser_fire = laser_fire_q;
    assign o_win_open   = win_open_q;
    assign o_miss       = miss_q;
    assign o_cfg_err    = cfg_err_q;
    assign o_busy       = busy_q;
    assign o_shot_cnt   = shot_cnt_q;

endmodule

// File: tb/tb_opto_shot_scheduler.sv
// Directed bench for opto_shot_scheduler: shot timeline, ready/miss handling, config
// shadowing, stop/drain and asynchronous reset, with hand-computed cycle offsets.
module tb_opto_shot_scheduler;

    logic        clk;
    logic        rst;
    logic        cfg_wr;
    logic [15:0] cfg_period;
    logic [15:0] cfg_lead;
    logic [15:0] cfg_win;
    logic        start;
    logic        stop;
    logic        tdc_ready;
    logic        tdc_init;
    logic        laser_fire;
    logic        win_open;
    logic        miss;
    logic        cfg_err;
    logic        busy;
    logic [31:0] shot_cnt;

    int checks   = 0;
    int failures = 0;

    opto_shot_scheduler dut (
        .i_clk        (clk),
        .i_rst        (rst),
        .i_cfg_wr     (cfg_wr),
        .i_cfg_period (cfg_period),
        .i_cfg_lead   (cfg_lead),
        .i_cfg_win    (cfg_win),
        .i_start      (start),
        .i_stop       (stop),
        .i_tdc_ready  (tdc_ready),
        .o_tdc_init   (tdc_init),
        .o_laser_fire (laser_fire),
        .o_win_open   (win_open),
        .o_miss       (miss),
        .o_cfg_err    (cfg_err),
        .o_busy       (busy),
        .o_shot_cnt   (shot_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Advance until a fire (kind 1) or miss (kind 2); n = cycles taken, -1 on timeout.
    task automatic wait_evt(input int max, output int n, output int kind);
        n    = -1;
        kind = 0;
        for (int i = 1; i <= max; i++) begin
            tick();
            if (laser_fire) begin
                n = i; kind = 1; break;
            end
            if (miss) begin
                n = i; kind = 2; break;
            end
        end
    endtask

    task automatic cfg_write(input logic [15:0] p, input logic [15:0] l, input logic [15:0] w);
        cfg_period = p;
        cfg_lead   = l;
        cfg_win    = w;
        cfg_wr     = 1'b1;
        tick();
        cfg_wr     = 1'b0;
    endtask

    initial begin
        int n;
        int kind;
        logic seen;

        rst = 1'b1; cfg_wr = 1'b0; cfg_period = 16'd0; cfg_lead = 16'd0; cfg_win = 16'd0;
        start = 1'b0; stop = 1'b0; tdc_ready = 1'b1;
        ticks(3);
        chk("rst_init", {31'd0, tdc_init}, 32'd0);
        chk("rst_fire", {31'd0, laser_fire}, 32'd0);
        chk("rst_win", {31'd0, win_open}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_cnt", shot_cnt, 32'd0);
        rst = 1'b0;
        tick();

        // Default timeline: init at T+263, fire at T+333, window T+334..T+533.
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("arm_busy", {31'd0, busy}, 32'd1);
        ticks(262);
        chk("def_init_early", {31'd0, tdc_init}, 32'd0);
        tick();
        chk("def_init", {31'd0, tdc_init}, 32'd1);
        ticks(69);
        chk("def_fire_early", {31'd0, laser_fire}, 32'd0);
        tick();
        chk("def_fire", {31'd0, laser_fire}, 32'd1);
        chk("def_cnt1", shot_cnt, 32'd1);
        tick();
        chk("def_win_first", {31'd0, win_open}, 32'd1);
        ticks(199);
        chk("def_win_last", {31'd0, win_open}, 32'd1);
        tick();
        chk("def_win_closed", {31'd0, win_open}, 32'd0);
        ticks(62);
        chk("def_init2", {31'd0, tdc_init}, 32'd1);
        ticks(70);
        chk("def_fire2", {31'd0, laser_fire}, 32'd1);
        chk("def_cnt2", shot_cnt, 32'd2);
        for (int i = 0; i < 8; i++) begin
            wait_evt(400, n, kind);
            chk("def_period", n, 32'd333);
            chk("def_kind", kind, 32'd1);
        end
        chk("def_cnt10", shot_cnt, 32'd10);

        // Stop during a window: the window runs its full 200 cycles, then idle.
        stop = 1'b1;
        tick();
        stop = 1'b0;
        chk("drain_busy", {31'd0, busy}, 32'd1);
        chk("drain_win", {31'd0, win_open}, 32'd1);
        ticks(199);
        chk("drain_win_last", {31'd0, win_open}, 32'd1);
        tick();
        chk("drain_win_done", {31'd0, win_open}, 32'd0);
        chk("drain_idle", {31'd0, busy}, 32'd0);

        // period=100 lead=20 win=30 in IDLE, ready pulsed at init+5.
        cfg_write(16'd100, 16'd20, 16'd30);
        chk("valid_no_err", {31'd0, cfg_err}, 32'd0);
        tdc_ready = 1'b0;
        start = 1'b1;
        tick();
        start = 1'b0;
        ticks(80);
        chk("c100_init", {31'd0, tdc_init}, 32'd1);
        ticks(5);
        tdc_ready = 1'b1;
        tick();
        tdc_ready = 1'b0;
        ticks(14);
        chk("c100_fire", {31'd0, laser_fire}, 32'd1);
        chk("c100_nomiss", {31'd0, miss}, 32'd0);
        tick();
        chk("c100_win_first", {31'd0, win_open}, 32'd1);
        ticks(29);
        chk("c100_win_last", {31'd0, win_open}, 32'd1);
        tick();
        chk("c100_win_closed", {31'd0, win_open}, 32'd0);
        ticks(54);
        tdc_ready = 1'b1;
        tick();
        tdc_ready = 1'b0;
        ticks(14);
        chk("c100_fire2", {31'd0, laser_fire}, 32'd1);

        // Ready held low for three periods: three misses, count frozen.
        for (int i = 0; i < 3; i++) begin
            wait_evt(150, n, kind);
            chk("miss_period", n, 32'd100);
            chk("miss_kind", kind, 32'd2);
        end
        chk("miss_cnt", shot_cnt, 32'd2);
        tdc_ready = 1'b1;
        wait_evt(150, n, kind);
        chk("recover_period", n, 32'd100);
        chk("recover_kind", kind, 32'd1);
        chk("recover_cnt", shot_cnt, 32'd3);

        // Ready only in the init cycle is ignored.
        tdc_ready = 1'b0;
        ticks(80);
        chk("initrdy_init", {31'd0, tdc_init}, 32'd1);
        tdc_ready = 1'b1;
        tick();
        tdc_ready = 1'b0;
        ticks(19);
        chk("initrdy_miss", {31'd0, miss}, 32'd1);
        chk("initrdy_nofire", {31'd0, laser_fire}, 32'd0);

        // Invalid writes: error pulse, timing unchanged.
        tdc_ready = 1'b1;
        cfg_write(16'd10, 16'd4, 16'd0);
        chk("err_period", {31'd0, cfg_err}, 32'd1);
        tick();
        chk("err_clear", {31'd0, cfg_err}, 32'd0);
        cfg_write(16'd100, 16'd2, 16'd0);
        chk("err_lead", {31'd0, cfg_err}, 32'd1);
        tick();
        cfg_write(16'd100, 16'd20, 16'd80);
        chk("err_win", {31'd0, cfg_err}, 32'd1);
        tick();
        wait_evt(150, n, kind);
        chk("err_timing_a", n, 32'd94);
        wait_evt(150, n, kind);
        chk("err_timing_b", n, 32'd100);

        // Valid period=200 mid-run: current period stays 100, next is 200.
        ticks(10);
        cfg_write(16'd200, 16'd20, 16'd30);
        chk("run_valid_no_err", {31'd0, cfg_err}, 32'd0);
        wait_evt(300, n, kind);
        chk("shadow_old", n, 32'd89);
        wait_evt(300, n, kind);
        chk("shadow_new", n, 32'd200);
        chk("shadow_kind", kind, 32'd1);

        // Stop between init and fire: abort without fire or miss.
        ticks(180);
        chk("abort_init", {31'd0, tdc_init}, 32'd1);
        ticks(5);
        stop = 1'b1;
        tick();
        stop = 1'b0;
        chk("abort_busy", {31'd0, busy}, 32'd1);
        tick();
        chk("abort_idle", {31'd0, busy}, 32'd0);
        seen = 1'b0;
        for (int i = 0; i < 250; i++) begin
            tick();
            seen = seen | laser_fire | miss | tdc_init | win_open;
        end
        chk("abort_quiet", {31'd0, seen}, 32'd0);
        start = 1'b1;
        stop  = 1'b1;
        tick();
        start = 1'b0;
        stop  = 1'b0;
        chk("start_stop_idle", {31'd0, busy}, 32'd0);

        // Asynchronous reset mid-window.
        cfg_write(16'd100, 16'd20, 16'd30);
        start = 1'b1;
        tick();
        start = 1'b0;
        wait_evt(150, n, kind);
        chk("rstwin_fire", n, 32'd100);
        chk("rstwin_cnt", shot_cnt, 32'd1);
        ticks(5);
        chk("rstwin_open", {31'd0, win_open}, 32'd1);
        #2;
        rst = 1'b1;
        #1;
        chk("async_win", {31'd0, win_open}, 32'd0);
        chk("async_busy", {31'd0, busy}, 32'd0);
        chk("async_cnt", shot_cnt, 32'd0);
        chk("async_pulses", {28'd0, tdc_init, laser_fire, miss, cfg_err}, 32'd0);
        ticks(2);
        rst = 1'b0;
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/opto_shot_scheduler.md
Name: opto_shot_scheduler

Overview:
Sequences each laser shot of the emission channel: a programmable per-shot timeline of TDC (GPX2) init, then a TDC-ready check, then the laser fire pulse, then the measurement window. Runtime-reconfigurable period, lead and window, with safe shadowed update at shot boundaries. Sits between the host/register block and the laser driver/TDC front end. Replaces the fixed-frequency pulse generator in the emission path.

Parameters:
DEF_PERIOD, 16'd333, reset shot period in clocks (≈300 kHz at 100 MHz)
DEF_LEAD, 16'd70, reset clocks from o_tdc_init to o_laser_fire
DEF_WIN, 16'd200, reset measurement-window length in clocks
MIN_PERIOD, 16'd16, smallest accepted period

Ports:
i_clk  in  1  system clock, 100 MHz
i_rst  in  1  asynchronous reset, active-high
i_cfg_wr  in  1  one-cycle strobe: validate and load i_cfg_* values
i_cfg_period  in  16  shot period in clocks
i_cfg_lead  in  16  init-to-fire lead in clocks
i_cfg_win  in  16  window length in clocks; 0 means no window
i_start  in  1  one-cycle strobe: begin shooting
i_stop  in  1  one-cycle strobe: stop shooting
i_tdc_ready  in  1  TDC ready level/pulse after init
o_tdc_init  out  1  one-cycle TDC init pulse
o_laser_fire  out  1  one-cycle laser fire pulse
o_win_open  out  1  measurement window active
o_miss  out  1  one-cycle pulse: shot skipped because TDC was not ready
o_cfg_err  out  1  one-cycle pulse: i_cfg_wr rejected
o_busy  out  1  high in ARM/RUN/DRAIN
o_shot_cnt  out  32  number of fired shots

Behaviour:
- One clock domain: i_clk. Reset is asynchronous and active-high on i_rst.
- Reset values: all outputs 0; state IDLE; active and pending config = DEF_*.
- All outputs are registered.
- Config validity rule: period >= MIN_PERIOD; 4 <= lead <= period-4; win <= period-lead-1.
  - A valid write pulses nothing.
  - An invalid write pulses o_cfg_err one cycle later, and both active and pending config stay unchanged.
- Config load timing:
  - In IDLE, a valid write becomes active on the next cycle.
  - In ARM/RUN/DRAIN, a valid write goes to pending. It becomes active at the next period wrap, i.e. the fire cycle, and governs the following period.
  - A later valid write overwrites pending.
- States: IDLE, RUN, DRAIN. ARM is the single cycle after i_start.
  - IDLE: i_start → ARM. Clears o_shot_cnt. i_start and i_stop in the same cycle → stay IDLE.
  - ARM → RUN. The period counter cnt starts at 0.
  - RUN: cnt counts 0..period-1 and wraps. If i_start is sampled at edge T, then:
    - o_tdc_init is high at cycle T+period-lead, and every period after.
    - The ready flag clears at the init cycle. It sets on any cycle from init+1 through fire-1 with i_tdc_ready=1. i_tdc_ready in the init cycle itself is ignored.
    - At cycle T+period, and every period after: if the flag is set, o_laser_fire=1 and o_shot_cnt increments. o_shot_cnt saturates at 32'hFFFFFFFF. If the flag is clear, o_miss=1 and there is no fire.
    - o_win_open is high for exactly win cycles starting at fire+1, and only after an actual fire.
    - i_start in RUN is ignored.
  - i_stop in RUN → DRAIN.
    - No further o_tdc_init or o_laser_fire.
    - A shot between init and fire is aborted with no fire and no o_miss.
    - An open window completes; then → IDLE.
    - With no window open, → IDLE next cycle.
  - i_stop in DRAIN/IDLE: no effect. i_start in DRAIN: ignored.
- Simultaneous i_cfg_wr and fire cycle: the new value goes to pending and is applied at the following wrap, not this one.
- Asynchronous reset mid-shot immediately forces all outputs to 0 and the state to IDLE. There is no trailing window.
- Arithmetic: 16-bit unsigned. The period-lead compare is precomputed at config activation. All compares are equality on cnt.

Test Plan:
- Reset defaults, i_tdc_ready tied 1, i_start at T:
  - Init at T+263, T+596, ...; fire at T+333, T+666, ...
  - o_win_open high T+334..T+533.
  - After 10 fires, o_shot_cnt=10.
- cfg period=100/lead=20/win=30 in IDLE; ready pulsed at init+5:
  - Fires exactly 100 clocks apart.
  - Window 30 cycles.
  - No o_miss.
- i_tdc_ready held 0 for 3 periods, then 1:
  - 3 o_miss pulses, 0 fires, o_shot_cnt unchanged.
  - Next period fires.
  - Ready asserted only in the init cycle → o_miss.
- Invalid writes (period=10; lead=2; win=period-lead) → o_cfg_err each time, timing unchanged.
- Valid write period=200 mid-RUN:
  - The current period keeps its old length.
  - The interval from the following fire to the next fire is 200.
- i_stop between init and fire → no fire, no miss, o_busy drops next cycle.
- i_stop during a window → window completes, then o_busy=0.
- i_rst asserted mid-window → all outputs 0 asynchronously.
